// File: rtl/adder_carry_chain_pipe_if.sv
// Handshake bundle for the pipelined carry-chain tile: P/G/carry-in request side
// and sum/carry-out response side, each with its own valid/ready pair.
interface adder_carry_chain_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] adder_carry_p;
    logic [WIDTH-1:0] adder_carry_g;
    logic             adder_carry_cin;
    logic [1:0]       cin_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] adder_carry_sumout;
    logic             adder_carry_cout;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output adder_carry_p, adder_carry_g, adder_carry_cin, cin_mode, in_valid, out_ready,
        input  in_ready, adder_carry_sumout, adder_carry_cout, out_valid
    );

    modport slave (
        input  adder_carry_p, adder_carry_g, adder_carry_cin, cin_mode, in_valid, out_ready,
        output in_ready, adder_carry_sumout, adder_carry_cout, out_valid
    );
endinterface

// File: rtl/adder_carry_chain_pipe.sv
// WIDTH-bit P/G carry chain cut into SEG_BITS-wide register stages with
// valid/ready flow control and a selectable carry-in (incl. chained carry-out).
module adder_carry_chain_pipe #(
    parameter int WIDTH    = 8,
    parameter int SEG_BITS = 4
) (
    input logic clk,
    input logic reset_n,
    adder_carry_chain_pipe_if.slave bus
);
    localparam int STAGES = (WIDTH + SEG_BITS - 1) / SEG_BITS;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
    } seg_t;

    logic [STAGES-1:0][WIDTH-1:0] stg_sum, stg_p, stg_g;
    logic [STAGES-1:0]            stg_c;
    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0]            adv;

    logic [STAGES-1:0][WIDTH-1:0] src_sum, src_p, src_g;
    logic [STAGES-1:0]            src_c, src_v;
    seg_t [STAGES-1:0]            nxt;

    logic cc;
    logic c0;
    logic ready;
    logic accept;
    logic out_fire;
    logic full;

    // Resolve the bits of segment k, passing already-resolved sum bits through.
    function automatic seg_t resolve_seg(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g,
                                         input logic [WIDTH-1:0] sum_in, input logic cin,
                                         input int k);
        seg_t r;
        logic c;
        r.sum = sum_in;
        c     = cin;
        for (int i = 0; i < WIDTH; i++) begin
            if (i / SEG_BITS == k) begin
                r.sum[i] = p[i] ^ c;
                c        = p[i] ? c : g[i];
            end
        end
        r.carry = c;
        return r;
    endfunction

    always_comb begin
        c0 = bus.adder_carry_cin;
        case (bus.cin_mode)
            2'd1:    c0 = 1'b0;
            2'd2:    c0 = 1'b1;
            2'd3:    c0 = cc;
            default: c0 = bus.adder_carry_cin;
        endcase
    end

    // A stage may load when it is empty or everything downstream can move.
    always_comb begin
        full = 1'b1;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full   = full & vld[k];
            adv[k] = !full || bus.out_ready;
        end
    end

    // Chained-carry transactions wait for an empty pipe so cc is up to date.
    assign ready    = reset_n && adv[0] && !(bus.cin_mode == 2'd3 && (|vld));
    assign accept   = bus.in_valid && ready;
    assign out_fire = vld[STAGES-1] && bus.out_ready;

    always_comb begin
        src_sum[0] = '0;
        src_p[0]   = bus.adder_carry_p;
        src_g[0]   = bus.adder_carry_g;
        src_c[0]   = c0;
        src_v[0]   = accept;
        for (int k = 1; k < STAGES; k++) begin
            src_sum[k] = stg_sum[k-1];
            src_p[k]   = stg_p[k-1];
            src_g[k]   = stg_g[k-1];
            src_c[k]   = stg_c[k-1];
            src_v[k]   = vld[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k] = resolve_seg(src_p[k], src_g[k], src_sum[k], src_c[k], k);
        end
    end

    // Stage registers: stage k captures segment k; the last one is the output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld     <= '0;
            stg_sum <= '0;
            stg_p   <= '0;
            stg_g   <= '0;
            stg_c   <= '0;
            cc      <= 1'b0;
        end else begin
            if (out_fire) begin
                cc <= stg_c[STAGES-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= src_v[k];
                    if (src_v[k]) begin
                        stg_sum[k] <= nxt[k].sum;
                        stg_p[k]   <= src_p[k];
                        stg_g[k]   <= src_g[k];
                        stg_c[k]   <= nxt[k].carry;
                    end
                end
            end
        end
    end

    assign bus.in_ready           = ready;
    assign bus.adder_carry_sumout = stg_sum[STAGES-1];
    assign bus.adder_carry_cout   = stg_c[STAGES-1];
    assign bus.out_valid          = vld[STAGES-1];
endmodule

// File: doc/adder_carry_chain_pipe.md
# adder_carry_chain_pipe

Parametrised, pipelined carry-chain tile for the CLB adder path. It extends the single-bit P/G/CI XOR-MUX2 carry cell to a WIDTH-bit chain. The chain is cut into register stages of SEG_BITS bits each, with valid/ready flow control and a selectable carry-in source. The selectable source includes chaining from the previous result's carry-out for multi-word arithmetic. It sits between the fle LUT outputs (producing P/G) and the CLB output crossbar.

## Interface
- WIDTH, 8: chain length in bits (≥1).
- SEG_BITS, 4: bits resolved per pipeline stage (1..WIDTH). STAGES = ceil(WIDTH/SEG_BITS).
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset (sampled on clk rising edge).
- adder_carry_p  in  WIDTH  propagate bits, bit 0 = LSB.
- adder_carry_g  in  WIDTH  generate bits.
- adder_carry_cin  in  1  external carry-in.
- cin_mode  in  2  0 = adder_carry_cin, 1 = force 0, 2 = force 1, 3 = previous committed cout.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- adder_carry_sumout  out  WIDTH  registered sum.
- adder_carry_cout  out  1  registered carry-out of bit WIDTH-1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

## Operation
- Per bit i: sum_i = p_i XOR c_i; c_{i+1} = p_i ? c_i : g_i; c_0 = selected carry-in.
- Stage k (0..STAGES-1) resolves bits [k·SEG_BITS, min((k+1)·SEG_BITS, WIDTH)-1] from the carry held in the stage k-1 register (stage 0 uses c_0). It registers:
  - resolved sum bits;
  - unresolved P/G bits;
  - the carry into the next segment;
  - valid bit v[k].
- The last stage register is the output register. out_valid = v[STAGES-1].
- Advance: adv[STAGES-1] = !v[STAGES-1] || out_ready; adv[k] = !v[k] || adv[k+1]. Stalled stages hold their contents unchanged.
- Carry-in source:
  - cin_mode is sampled only on acceptance.
  - The selected carry is captured into stage 0 with the data.
- Committed-carry register cc:
  - Loads adder_carry_cout on every output handshake.
  - Mode 3 uses cc.
- Mode-3 interlock:
  - in_ready = adv[0] && !(cin_mode==3 && any v[k]).
  - A mode-3 transaction therefore enters only when the pipeline is empty, so cc reflects every earlier transaction.
  - in_ready combinationally depends on cin_mode, out_ready and state only, never on in_valid.
- Ordering: strict FIFO. No reordering and no drops.

## Timing
- Reset (reset_n low at a rising edge):
  - all v[k] = 0, all data registers = 0, cc = 0.
  - Outputs: out_valid 0, adder_carry_sumout 0, adder_carry_cout 0.
  - in_ready is 0 while reset_n is low and 1 on the first cycle after release.
- Reset mid-operation: every in-flight transaction is discarded with no output handshake. cc returns to 0.
- Latency: a transaction accepted at edge N presents out_valid at edge N+STAGES-1 (registered after STAGES edges; visible in the cycle following edge N+STAGES-1 capture). Example: STAGES = 2 gives 2 cycles from acceptance to valid output.
- Throughput: 1 transaction/clock with out_ready held high and modes 0–2.
- Mode 3 back-to-back: issue stalls until the previous transaction's output handshake completes. Maximum rate is 1 per STAGES+1 clocks.
- Simultaneous output handshake and input acceptance on a full pipeline: both occur on the same edge; no bubble.
- out_ready low: the output holds stable sumout/cout/out_valid. Upstream stages fill, then in_ready falls.
- WIDTH not a multiple of SEG_BITS: the last stage is narrower. SEG_BITS = WIDTH gives a single stage (latency 1).

## Test plan
- WIDTH=8, SEG_BITS=4, mode 0, cin=0, p=0x66, g=0x18 (0x5A+0x3C) -> 2 cycles later sumout=0x96, cout=0, out_valid for exactly one cycle with out_ready=1.
- Mode 0, cin=0, p=0xFE, g=0x01 (0xFF+0x01) -> sumout=0x00, cout=1. Then mode 3, p=0x00, g=0x00 -> in_ready low until the first output handshake, then result sumout=0x01, cout=0.
- Mode 2, p=0xFF, g=0x00 -> sumout=0x00, cout=1. Mode 1 with cin=1, same P/G -> sumout=0xFF, cout=0.
- Stream of 6 mode-0 transactions, out_ready low for 4 cycles mid-stream -> output held stable; in_ready low once 2 in flight; all 6 results emerge in order with correct values; no duplicate or lost handshake.
- reset_n low for one cycle with 2 transactions in flight and cc=1 -> out_valid=0, sumout=0, cout=0 next cycle. A following mode-3 transaction with p=g=0 yields sumout=0x00, cout=0.
- WIDTH=7, SEG_BITS=3 (3 stages), p=0x7F, g=0x00, mode 2 -> sumout=0x00, cout=1, exactly 3 cycles after acceptance.
